gh_fifo_sync_sr: RTL

//  Single-clock synchronous FIFO: parametrised width and depth, occupancy count,

---
 rtl/gh_fifo_pkg.sv | 45 ++++
 rtl/gh_fifo_ram_dp.sv | 31 +++
 rtl/gh_fifo_sync_sr.sv | 130 +++++++++++++
 3 files changed

// File: rtl/gh_fifo_pkg.sv
// Shared helpers for the gh_fifo family: width calculation, parameter
// legality check and the per-cycle operation encoding.
package gh_fifo_pkg;

    // Ceiling log2, used to size pointers and the occupancy counter.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    // True when the parameter set describes a buildable FIFO.
    function automatic bit params_legal(
        input int data_width,
        input int depth,
        input int af_level,
        input int ae_level,
        input int fwft
    );
        return (data_width >= 1)
            && (depth >= 4) && is_pow2(depth)
            && (af_level >= 1) && (af_level <= depth)
            && (ae_level >= 0) && (ae_level <= depth - 1)
            && ((fwft == 0) || (fwft == 1));
    endfunction

    // Accepted operations in one cycle, encoded as {write, read}.
    typedef enum logic [1:0] {
        FIFO_OP_IDLE = 2'b00,
        FIFO_OP_RD   = 2'b01,
        FIFO_OP_WR   = 2'b10,
        FIFO_OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/gh_fifo_ram_dp.sv
// Simple dual-port storage: synchronous write port, asynchronous read port.
module gh_fifo_ram_dp
    import gh_fifo_pkg::*;
#(
    parameter int data_width = 8,
    parameter int depth      = 16
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [clog2(depth)-1:0]   wr_addr,
    input  logic [data_width-1:0]     wr_data,
    input  logic [clog2(depth)-1:0]   rd_addr,
    output logic [data_width-1:0]     rd_data
);

    logic [data_width-1:0] mem [depth];

    // Store the write word at the write address on an accepted write.
    // NOTE: the array has no reset -- contents are don't-care until written,
    // and leaving it out lets the tools map it onto RAM instead of flops.
    // NOTE: clocked state is always assigned with <= so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/gh_fifo_sync_sr.sv
// Single-clock FIFO with occupancy count, programmable almost flags,
// overflow/underflow strobes and registered or fall-through read data.
module gh_fifo_sync_sr
    import gh_fifo_pkg::*;
#(
    parameter int data_width = 8,
    parameter int depth      = 16,
    parameter int af_level   = 12,
    parameter int ae_level   = 4,
    parameter int fwft       = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    srst,
    input  logic                    WR,
    input  logic                    RD,
    input  logic [data_width-1:0]   D,
    output logic [data_width-1:0]   Q,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_empty,
    output logic                    almost_full,
    output logic [clog2(depth):0]   count,
    output logic                    ovf,
    output logic                    udf
);

    localparam int AW = clog2(depth);

    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(depth);
    localparam logic [AW:0]   AF_CNT    = (AW+1)'(af_level);
    localparam logic [AW:0]   AE_CNT    = (AW+1)'(ae_level);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    if (!params_legal(data_width, depth, af_level, ae_level, fwft)) begin : g_param_check
        $error("gh_fifo_sync_sr: illegal parameters (depth must be a power of 2 >= 4, 1 <= af_level <= depth, 0 <= ae_level < depth)");
    end

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  wr_en;
    logic                  rd_en;
    fifo_op_e              op;
    logic [data_width-1:0] ram_q;
    logic [data_width-1:0] q_reg;

    // Requests are only honoured when they cannot corrupt the occupancy.
    assign wr_en = WR && !full;
    assign rd_en = RD && !empty;
    assign op    = fifo_op_e'({wr_en, rd_en});

    gh_fifo_ram_dp #(
        .data_width (data_width),
        .depth      (depth)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (D),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    // Advance pointers on accepted accesses and track occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case (op)
                FIFO_OP_WR: count <= count + CNT_ONE;
                FIFO_OP_RD: count <= count - CNT_ONE;
                default:    count <= count;
            endcase
        end
    end

    // One-cycle strobes flagging requests dropped at the full/empty limits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else if (srst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= WR && full;
            udf <= RD && empty;
        end
    end

    // Registered read data: capture the head word on an accepted read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg <= '0;
        end else if (srst) begin
            q_reg <= '0;
        end else if (rd_en) begin
            q_reg <= ram_q;
        end
    end

    // Select between the registered word and the live head word.
    // NOTE: Q gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        Q = q_reg;
        if (fwft != 0) begin
            Q = empty ? '0 : ram_q;
        end
    end

    assign empty        = (count == '0);
    assign full         = (count == DEPTH_CNT);
    assign almost_empty = (count <= AE_CNT);
    assign almost_full  = (count >= AF_CNT);

endmodule
